// File: rtl/sd_stripe_mux_pkg.sv
// ---------------------------------------------------------------------------
// sd_stripe_pkg
// Shared types and helpers for the RAID5 stripe distributor.
//   state_e        : controller states (IDLE / ACTIVE / DRAIN)
//   chan_word_idx  : which input data word feeds a non-parity channel
// ---------------------------------------------------------------------------
package sd_stripe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Data word carried by channel ch when parity sits on channel par (ch != par).
  // Channels below the parity slot take their own index; channels above it
  // shift down by one because the parity slot consumes no data word.
  function automatic int unsigned chan_word_idx(input int unsigned ch,
                                                input int unsigned par);
    return (ch < par) ? ch : ch - 1;
  endfunction

endpackage

// File: rtl/sd_stripe_mux_if.sv
// ---------------------------------------------------------------------------
// sd_stripe_mux_if
// Input beat stream (from the SRAM buffers) and striped output stream
// (to the SD write channels) of the stripe distributor.
//   in_data/in_valid/in_ready          : NUM_SD-1 data words per beat
//   out_data/out_en/out_valid/out_ready: NUM_SD channel words per beat
// modport slave  : the distributor
// modport master : whoever drives the input and consumes the output
// ---------------------------------------------------------------------------
interface sd_stripe_mux_if #(
  parameter int DATA_W = 32,
  parameter int NUM_SD = 4
) ();

  logic [(NUM_SD-1)*DATA_W-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_SD*DATA_W-1:0]     out_data;
  logic [NUM_SD-1:0]            out_en;
  logic                         out_valid;
  logic                         out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_en, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_en, out_valid
  );

endinterface

// File: rtl/sd_stripe_mux_parity_gen.sv
// ---------------------------------------------------------------------------
// sd_parity_gen
// Combinational XOR reduction of N words of DATA_W bits.
//   words_i  : word k at [k*DATA_W +: DATA_W]
//   parity_o : XOR of all N words
// ---------------------------------------------------------------------------
module sd_parity_gen #(
  parameter int N      = 3,
  parameter int DATA_W = 32
) (
  input  logic [N*DATA_W-1:0] words_i,
  output logic [DATA_W-1:0]   parity_o
);

  always_comb begin
    parity_o = '0;
    for (int k = 0; k < N; k++) begin
      parity_o = parity_o ^ words_i[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/sd_stripe_mux.sv
// ---------------------------------------------------------------------------
// sd_stripe_mux
// RAID5 stripe distributor: takes one beat of NUM_SD-1 data words, adds XOR
// parity and routes data + parity to NUM_SD SD write channels through one
// registered, handshaked stage. The parity channel rotates after every
// WORDS_PER_BLK beats; an optional failed channel has its enable cleared.
// Ports:
//   clk, n_rst         : clock, asynchronous active-low reset
//   start, num_blocks  : begin a transfer of num_blocks blocks (IDLE only)
//   par_start          : parity channel of the first block
//   fail_en, fail_id   : degraded mode, channel fail_id gets out_en=0
//   abort              : synchronous cancel back to IDLE (no done)
//   bus                : input beat / striped output streams (slave side)
//   par_id             : parity channel applied to the next accepted beat
//   busy, done         : transfer in progress / one-cycle end pulse
// ---------------------------------------------------------------------------
module sd_stripe_mux
  import sd_stripe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int NUM_SD        = 4,
  parameter int WORDS_PER_BLK = 128,
  parameter int CNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_blocks,
  input  logic [$clog2(NUM_SD)-1:0] par_start,
  input  logic                      fail_en,
  input  logic [$clog2(NUM_SD)-1:0] fail_id,
  input  logic                      abort,
  sd_stripe_mux_if.slave            bus,
  output logic [$clog2(NUM_SD)-1:0] par_id,
  output logic                      busy,
  output logic                      done
);

  localparam int PID_W = $clog2(NUM_SD);
  localparam int WC_W  = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;

  state_e                   state_q, state_d;
  logic [WC_W-1:0]          word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]         blk_cnt_q, blk_cnt_d;
  logic [PID_W-1:0]         par_id_q, par_id_d;
  logic                     fail_en_q, fail_en_d;
  logic [PID_W-1:0]         fail_id_q, fail_id_d;
  logic [NUM_SD*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_SD-1:0]        out_en_q, out_en_d;
  logic                     out_valid_q, out_valid_d;
  logic                     done_q, done_d;

  logic [DATA_W-1:0]        parity;
  logic [NUM_SD*DATA_W-1:0] mapped;
  logic [NUM_SD-1:0]        en_mask;
  logic                     in_ready, accept_in, accept_out;
  logic                     last_word, last_blk;

  sd_parity_gen #(.N(NUM_SD-1), .DATA_W(DATA_W)) u_parity (
    .words_i  (bus.in_data),
    .parity_o (parity)
  );

  // Output register may be refilled in the same cycle it is drained.
  assign in_ready   = (state_q == ACTIVE) && (!out_valid_q || bus.out_ready);
  assign accept_in  = bus.in_valid && in_ready;
  assign accept_out = out_valid_q && bus.out_ready;
  assign last_word  = (word_cnt_q == WC_W'(WORDS_PER_BLK-1));
  assign last_blk   = (blk_cnt_q == CNT_W'(1));

  // Channel routing for the beat on the input, using the current parity slot.
  always_comb begin
    mapped  = '0;
    en_mask = '1;
    for (int c = 0; c < NUM_SD; c++) begin
      if (c == int'(par_id_q)) begin
        mapped[c*DATA_W +: DATA_W] = parity;
      end else begin
        mapped[c*DATA_W +: DATA_W] =
          bus.in_data[chan_word_idx(c, 32'(par_id_q))*DATA_W +: DATA_W];
      end
    end
    // The failed channel still carries its data; only its enable drops.
    if (fail_en_q) en_mask[fail_id_q] = 1'b0;
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    par_id_d    = par_id_q;
    fail_en_d   = fail_en_q;
    fail_id_d   = fail_id_q;
    out_data_d  = out_data_q;
    out_en_d    = out_en_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            state_d    = ACTIVE;
            word_cnt_d = '0;
            blk_cnt_d  = num_blocks;
            par_id_d   = (int'(par_start) >= NUM_SD) ? '0 : par_start;
            fail_en_d  = fail_en;
            fail_id_d  = fail_id;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (accept_in) begin
          if (last_word) begin
            word_cnt_d = '0;
            blk_cnt_d  = blk_cnt_q - CNT_W'(1);
            par_id_d   = (par_id_q == PID_W'(NUM_SD-1)) ? '0
                                                         : par_id_q + PID_W'(1);
            if (last_blk) state_d = DRAIN;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_in) begin
      out_data_d  = mapped;
      out_en_d    = en_mask;
      out_valid_d = 1'b1;
    end else if (accept_out) begin
      out_valid_d = 1'b0;
    end

    // Abort overrides everything, including a coincident start.
    if (abort) begin
      state_d     = IDLE;
      word_cnt_d  = '0;
      blk_cnt_d   = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      par_id_q    <= '0;
      fail_en_q   <= 1'b0;
      fail_id_q   <= '0;
      // NOTE: the data register is reset as well, because out_data and
      // out_en must read zero out of reset; it is a pipeline stage, not a
      // memory array.
      out_data_q  <= '0;
      out_en_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      par_id_q    <= par_id_d;
      fail_en_q   <= fail_en_d;
      fail_id_q   <= fail_id_d;
      out_data_q  <= out_data_d;
      out_en_q    <= out_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_en    = out_en_q;
  assign bus.out_valid = out_valid_q;
  assign par_id        = par_id_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_sd_stripe_mux.sv
// ---------------------------------------------------------------------------
// tb_sd_stripe_mux
// Self-checking bench for sd_stripe_mux with NUM_SD=4, WORDS_PER_BLK=4.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// A scoreboard holds the expected stripe of every accepted beat, built from
// the beat index: block b uses parity channel (par_start + b) mod NUM_SD,
// the data words fill the remaining channels in ascending order.
// ---------------------------------------------------------------------------
module tb_sd_stripe_mux;

  localparam int DATA_W = 32;
  localparam int NUM_SD = 4;
  localparam int WPB    = 4;
  localparam int CNT_W  = 16;
  localparam int PID_W  = 2;
  localparam int BUDGET = 400;

  typedef struct {
    logic [NUM_SD*DATA_W-1:0] d;
    logic [NUM_SD-1:0]        e;
  } beat_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic [CNT_W-1:0]  num_blocks;
  logic [PID_W-1:0]  par_start;
  logic              fail_en;
  logic [PID_W-1:0]  fail_id;
  logic              abort;
  logic [PID_W-1:0]  par_id;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [NUM_SD*DATA_W-1:0] first_out;
  int                       blk_pid[$];

  sd_stripe_mux_if #(.DATA_W(DATA_W), .NUM_SD(NUM_SD)) bus ();

  sd_stripe_mux #(
    .DATA_W(DATA_W), .NUM_SD(NUM_SD), .WORDS_PER_BLK(WPB), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .num_blocks (num_blocks),
    .par_start  (par_start),
    .fail_en    (fail_en),
    .fail_id    (fail_id),
    .abort      (abort),
    .bus        (bus),
    .par_id     (par_id),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Reference stripe: parity on channel pid, data words fill the rest in order.
  function automatic logic [NUM_SD*DATA_W-1:0] ref_stripe(
      input logic [(NUM_SD-1)*DATA_W-1:0] w, input int pid);
    logic [DATA_W-1:0]        p;
    logic [NUM_SD*DATA_W-1:0] r;
    int                       k;
    p = '0;
    r = '0;
    for (int i = 0; i < NUM_SD-1; i++) p = p ^ w[i*DATA_W +: DATA_W];
    k = 0;
    for (int c = 0; c < NUM_SD; c++) begin
      if (c == pid) begin
        r[c*DATA_W +: DATA_W] = p;
      end else begin
        r[c*DATA_W +: DATA_W] = w[k*DATA_W +: DATA_W];
        k++;
      end
    end
    return r;
  endfunction

  // Full transfer with scoreboard. rnd randomises in_valid/out_ready, fixed
  // sends words {1,2,4}, stall_beat/stall_len hold out_ready low once, and
  // restart_cyc pulses a conflicting start while busy (-1 = never).
  task automatic run_xfer(input int nb, input int ps, input bit fen, input int fid,
                          input bit rnd, input bit fixed, input int stall_beat,
                          input int stall_len, input int restart_cyc);
    beat_t             exp_q[$];
    beat_t             b;
    int                total, sent, got, stall_cnt, cyc, pid;
    bit                expect_done, fin, held, exp_ir;
    logic [NUM_SD*DATA_W-1:0] held_data;
    logic [NUM_SD-1:0] held_en, en_exp;
    total = nb * WPB;
    sent = 0; got = 0; stall_cnt = 0; cyc = 0;
    expect_done = 0; fin = 0; held = 0;
    held_data = '0; held_en = '0;
    en_exp = '1;
    if (fen) en_exp[fid] = 1'b0;
    blk_pid.delete();

    @(negedge clk);
    start = 1'b1; num_blocks = CNT_W'(nb); par_start = PID_W'(ps);
    fail_en = fen; fail_id = PID_W'(fid);
    @(negedge clk);
    start = 1'b0; fail_en = 1'b0; fail_id = '0;

    while (!fin && cyc < BUDGET) begin
      start = (cyc == restart_cyc);
      if (start) begin
        num_blocks = CNT_W'(3);
        par_start  = PID_W'((ps + 1) % NUM_SD);
      end
      bus.in_valid = (sent < total) && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_data  = fixed ? {32'h4, 32'h2, 32'h1} : {$urandom, $urandom, $urandom};
      if (got == stall_beat && stall_cnt < stall_len) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.out_ready = !rnd || ($urandom_range(0, 3) != 0);
      end
      #1;
      if (expect_done) begin
        check(done === 1'b1 && busy === 1'b0,
              $sformatf("done_end got done=%b busy=%b exp done=1 busy=0", done, busy));
        fin = 1;
      end else begin
        check(done === 1'b0, $sformatf("early_done got %b exp 0", done));
        exp_ir = (sent < total) && (!bus.out_valid || bus.out_ready);
        check(bus.in_ready === exp_ir,
              $sformatf("in_ready beat %0d got %b exp %b", sent, bus.in_ready, exp_ir));
        if (held) begin
          check(bus.out_data === held_data && bus.out_en === held_en,
                $sformatf("stall_stable got %h/%b exp %h/%b",
                          bus.out_data, bus.out_en, held_data, held_en));
        end
        if (bus.in_valid && bus.in_ready) begin
          pid = (ps + sent / WPB) % NUM_SD;
          check(par_id === PID_W'(pid),
                $sformatf("par_id beat %0d got %0d exp %0d", sent, par_id, pid));
          if (sent % WPB == 0) blk_pid.push_back(int'(par_id));
          b.d = ref_stripe(bus.in_data, pid);
          b.e = en_exp;
          exp_q.push_back(b);
          sent++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, $sformatf("extra_out got %h exp none", bus.out_data));
          end else begin
            b = exp_q.pop_front();
            check(bus.out_data === b.d && bus.out_en === b.e,
                  $sformatf("out beat %0d got %h/%b exp %h/%b",
                            got, bus.out_data, bus.out_en, b.d, b.e));
          end
          if (got == 0) first_out = bus.out_data;
          got++;
          if (got == total) expect_done = 1;
        end
        held      = bus.out_valid && !bus.out_ready;
        held_data = bus.out_data;
        held_en   = bus.out_en;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check(fin, $sformatf("timeout sent %0d got %0d exp %0d", sent, got, total));
    #1;
    check(done === 1'b0 && busy === 1'b0 && bus.out_valid === 1'b0,
          $sformatf("after_done got done=%b busy=%b ov=%b exp 0 0 0",
                    done, busy, bus.out_valid));
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; num_blocks = '0;
    par_start = '0; fail_en = 1'b0; fail_id = '0;
    bus.in_valid = 1'b1; bus.in_data = '1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check(bus.in_ready === 1'b0 && bus.out_valid === 1'b0 && bus.out_data === '0 &&
          bus.out_en === '0 && par_id === '0 && busy === 1'b0 && done === 1'b0,
          $sformatf("reset_vals got ir=%b ov=%b od=%h oe=%b pid=%0d busy=%b done=%b exp all 0",
                    bus.in_ready, bus.out_valid, bus.out_data, bus.out_en, par_id, busy, done));
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check(busy === 1'b0 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0 && done === 1'b0,
          $sformatf("post_reset got busy=%b ir=%b ov=%b done=%b exp 0 0 0 0",
                    busy, bus.in_ready, bus.out_valid, done));
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic;
    run_xfer(1, 2, 1'b0, 0, 1'b0, 1'b1, -1, 0, -1);
    check(first_out === {32'h4, 32'h7, 32'h2, 32'h1},
          $sformatf("basic_map got %h exp %h", first_out, {32'h4, 32'h7, 32'h2, 32'h1}));
  endtask

  task automatic test_multi_block;
    run_xfer(3, 3, 1'b0, 0, 1'b0, 1'b0, -1, 0, -1);
    if (blk_pid.size() != 3)
      check(1'b0, $sformatf("blk_count got %0d exp 3", blk_pid.size()));
    else
      check(blk_pid[0] == 3 && blk_pid[1] == 0 && blk_pid[2] == 1,
            $sformatf("pid_seq got %0d,%0d,%0d exp 3,0,1", blk_pid[0], blk_pid[1], blk_pid[2]));
  endtask

  task automatic test_stall;
    run_xfer(2, 1, 1'b0, 0, 1'b0, 1'b0, 2, 5, -1);
  endtask

  task automatic test_fail_mode;
    run_xfer(2, 0, 1'b1, 1, 1'b0, 1'b0, -1, 0, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++)
      run_xfer(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
               1'b0, 0, 1'b1, 1'b0, -1, 0, -1);
  endtask

  task automatic test_abort;
    int acc = 0;
    int cyc = 0;
    @(negedge clk);
    start = 1'b1; num_blocks = CNT_W'(2); par_start = '0;
    @(negedge clk);
    start = 1'b0;
    bus.out_ready = 1'b1;
    while (acc < 5 && cyc < 100) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom, $urandom};
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check(busy === 1'b0 && bus.out_valid === 1'b0 && bus.in_ready === 1'b0 && done === 1'b0,
          $sformatf("abort got busy=%b ov=%b ir=%b done=%b exp 0 0 0 0",
                    busy, bus.out_valid, bus.in_ready, done));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check(done === 1'b0, $sformatf("abort_no_done got %b exp 0", done));
    end
    // Abort together with start keeps the block idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_blocks = CNT_W'(1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check(busy === 1'b0 && done === 1'b0,
          $sformatf("abort_beats_start got busy=%b done=%b exp 0 0", busy, done));
  endtask

  task automatic test_zero_blocks;
    @(negedge clk);
    start = 1'b1; num_blocks = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check(done === 1'b1 && busy === 1'b0,
          $sformatf("zero_done got done=%b busy=%b exp 1 0", done, busy));
    @(negedge clk);
    #1;
    check(done === 1'b0 && busy === 1'b0,
          $sformatf("zero_pulse got done=%b busy=%b exp 0 0", done, busy));
  endtask

  task automatic test_start_busy;
    run_xfer(1, 1, 1'b0, 0, 1'b0, 1'b0, -1, 0, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_block();
    test_stall();
    test_fail_mode();
    test_random();
    test_abort();
    test_zero_blocks();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
